pio_edge_irq_in: RTL
====================

// Module: pio_edge_irq_in
// PURPOSE
//  Parametrised Avalon-MM input PIO; successor to the fixed 4-bit DIP-switch PIO.
//  Synchronises WIDTH asynchronous inputs and debounces each channel with a
//  programmable, per-block hold time. Captures rising and/or falling edges per channel
//  with per-bit enables, and raises a level IRQ to the HPS/LW bridge interrupt fabric.
//  Sits on the lightweight HPS-to-FPGA bus beside the LED/button PIOs.
// PARAMETERS
//  WIDTH        4     number of input channels, 1..32
//  SYNC_STAGES  2     synchroniser flops per channel, 2..4
//  DB_W         16    debounce counter / DEBOUNCE register width, 1..32
//  DB_RST       0     reset value of DEBOUNCE register (cycles)
//  RISE_RST     all-1 reset value of RISE_EN[WIDTH-1:0]
//  FALL_RST     all-1 reset value of FALL_EN[WIDTH-1:0]
// PORTS
//  clk         in   1      single clock; all logic on posedge
//  reset       in   1      synchronous, active-high reset
//  address     in   3      word address of register
//  chipselect  in   1      slave select
//  write_n     in   1      active-low write strobe (write = chipselect & ~write_n)
//  writedata   in   32     write data
//  in_port     in   WIDTH  asynchronous inputs
//  readdata    out  32     registered read data, upper bits zero
//  irq         out  1      level interrupt, active-high
// BEHAVIOUR
//  Register map, unused bits read 0:
//   0 DATA  RO  debounced value
//   1 RAW   RO  synchroniser output
//   2 IRQ_MASK  RW
//   3 EDGE_CAPTURE  RW1C
//   4 RISE_EN   RW
//   5 FALL_EN   RW
//   6 DEBOUNCE  RW [DB_W-1:0]
//   7 reserved, reads 0, writes ignored
//  Reset:
//   - sync chain, debounced, prev, counters, IRQ_MASK, EDGE_CAPTURE and readdata clear to 0.
//   - RISE_EN=RISE_RST, FALL_EN=FALL_RST, DEBOUNCE=DB_RST, irq=0.
//   - Reset asserted mid-debounce discards the count; no edge is generated by reset itself.
//  Read:
//   - readdata <= mux(address) on every clk; one-cycle latency, chipselect not required.
//  Sync:
//   - sync[0] <= in_port; sync[i] <= sync[i-1]; RAW = sync[SYNC_STAGES-1].
//  Debounce, per channel c, L = DEBOUNCE:
//   - if RAW[c]==deb[c]: cnt[c] <= 0.
//   - else if L<=1 or cnt[c]==L-1: deb[c] <= RAW[c], cnt[c] <= 0.
//   - else: cnt[c] <= cnt[c]+1.
//   - Any bounce back to deb[c] restarts the count; a mismatch shorter than L cycles is discarded.
//   - cnt never wraps: it is bounded by L-1.
//   - Writing DEBOUNCE mid-count takes effect next cycle. If cnt >= new L-1, the update happens on the next mismatch cycle.
//  Edge detect:
//   - prev <= deb each cycle.
//   - ev = (deb & ~prev & RISE_EN) | (~deb & prev & FALL_EN).
//  EDGE_CAPTURE[c]:
//   - set when ev[c].
//   - cleared by a write to addr 3 with writedata[c]=1.
//   - Simultaneous set and clear: set wins, so no event is lost.
//   - Bits stay set when RISE_EN/FALL_EN are later cleared.
//  irq = |(EDGE_CAPTURE & IRQ_MASK), combinational from registers.
//  Latency:
//   - An in_port change stable from edge 0 updates deb at edge SYNC_STAGES+max(L,1)-1.
//   - EDGE_CAPTURE and irq follow one edge later.
//   - With defaults (SYNC_STAGES=2, L=0): set after the 4th rising edge.
//  Power-up: an input held high through reset produces a rising edge once it is debounced.
// TESTING
//  1. Defaults, IRQ_MASK=0x1, in_port[0] 0->1: EDGE_CAPTURE=0x1 and irq=1 exactly 4 edges after the change. Write 0x1 to addr 3 -> irq=0 next cycle.
//  2. DEBOUNCE=4, in_port[1] high-pulse of 3 cycles -> DATA, EDGE_CAPTURE unchanged. Pulse of 4 cycles -> DATA[1]=1, EDGE_CAPTURE[1]=1.
//  3. RISE_EN=0xF, FALL_EN=0x0: toggle in_port[2] 0->1->0 -> one capture only, on the rise. Swap enables -> capture only on the fall.
//  4. Clear write to addr 3 (0x8) in the same cycle as a new ev[3] -> EDGE_CAPTURE[3] remains 1.
//  5. DEBOUNCE=8, assert reset 5 cycles into a mismatch -> all registers at reset values, irq=0, readdata=0. Input still high -> capture after full re-debounce.
//  6. WIDTH=32, SYNC_STAGES=3: walk a 1 across in_port -> each bit captured in isolation. Read addr 7 -> 0. readdata valid one cycle after address.

Source files
------------

// File: rtl/pio_edge_irq_in.sv
// Avalon-MM input PIO: synchronised, debounced inputs with per-bit rise/fall edge
// capture and a level interrupt.
module pio_edge_irq_in #(
  parameter int unsigned       WIDTH       = 4,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter int unsigned       DB_W        = 16,
  parameter logic [DB_W-1:0]   DB_RST      = '0,
  parameter logic [WIDTH-1:0]  RISE_RST    = '1,
  parameter logic [WIDTH-1:0]  FALL_RST    = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  typedef enum logic [2:0] {
    A_DATA = 3'd0,
    A_RAW  = 3'd1,
    A_MASK = 3'd2,
    A_EDGE = 3'd3,
    A_RISE = 3'd4,
    A_FALL = 3'd5,
    A_DEB  = 3'd6,
    A_RSVD = 3'd7
  } addr_e;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [DB_W-1:0]  cnt_q  [WIDTH];
  logic [WIDTH-1:0] raw, deb_q, prev_q, mask_q, edge_q, rise_q, fall_q;
  logic [WIDTH-1:0] ev, clr;
  logic [DB_W-1:0]  db_len_q, len_m1;
  logic             len_short, wr_en;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  assign wr_en     = chipselect & ~write_n;
  assign raw       = sync_q[SYNC_STAGES-1];
  assign len_short = (db_len_q <= DB_W'(1));
  assign len_m1    = db_len_q - DB_W'(1);
  assign ev        = (deb_q & ~prev_q & rise_q) | (~deb_q & prev_q & fall_q);
  assign clr       = (wr_en && addr_e'(address) == A_EDGE) ? writedata[WIDTH-1:0] : '0;
  assign irq       = |(edge_q & mask_q);
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // ">=" rather than "==" so a shortened hold time mid-count still resolves next cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_q <= '0;
      for (int unsigned c = 0; c < WIDTH; c++) cnt_q[c] <= '0;
    end else begin
      for (int unsigned c = 0; c < WIDTH; c++) begin
        if (raw[c] == deb_q[c]) begin
          cnt_q[c] <= '0;
        end else if (len_short || cnt_q[c] >= len_m1) begin
          deb_q[c] <= raw[c];
          cnt_q[c] <= '0;
        end else begin
          cnt_q[c] <= cnt_q[c] + DB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q   <= '0;
      mask_q   <= '0;
      edge_q   <= '0;
      rise_q   <= RISE_RST;
      fall_q   <= FALL_RST;
      db_len_q <= DB_RST;
      readdata <= '0;
    end else begin
      prev_q   <= deb_q;
      edge_q   <= (edge_q & ~clr) | ev;
      readdata <= rd_mux;
      if (wr_en) begin
        case (addr_e'(address))
          A_MASK:  mask_q   <= writedata[WIDTH-1:0];
          A_RISE:  rise_q   <= writedata[WIDTH-1:0];
          A_FALL:  fall_q   <= writedata[WIDTH-1:0];
          A_DEB:   db_len_q <= writedata[DB_W-1:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (addr_e'(address))
      A_DATA:  rd_mux[WIDTH-1:0] = deb_q;
      A_RAW:   rd_mux[WIDTH-1:0] = raw;
      A_MASK:  rd_mux[WIDTH-1:0] = mask_q;
      A_EDGE:  rd_mux[WIDTH-1:0] = edge_q;
      A_RISE:  rd_mux[WIDTH-1:0] = rise_q;
      A_FALL:  rd_mux[WIDTH-1:0] = fall_q;
      A_DEB:   rd_mux[DB_W-1:0]  = db_len_q;
      A_RSVD:  rd_mux = '0;
      default: rd_mux = '0;
    endcase
  end

endmodule
